// File: rtl/univ_shift_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_pkg
// Shared definitions for the universal shift register:
//   mode_e        - 3-bit operation encodings (HOLD..CLR)
//   state_e       - control FSM states (IDLE/BUSY), one-hot so that a
//                   corrupted encoding is detectable and recoverable
//   is_burst_mode - true for the modes that may run as a multi-cycle burst
// -----------------------------------------------------------------------------
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  // Two legal codes out of four; the other two fall back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_BUSY = 2'b10
  } state_e;

  // Only the shift/rotate family may be repeated as a burst.
  function automatic logic is_burst_mode(input mode_e m);
    logic r;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: r = 1'b1;
      default:                                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_shift_core.sv
// -----------------------------------------------------------------------------
// usr_shift_core
// Purely combinational next-value function of the universal shift register.
// Shared by the single-cycle (En) path and the burst path so both execute
// exactly the same operation definitions.
//   Q       in  current register contents
//   Din     in  parallel load data
//   mode    in  operation select
//   SinLsb  in  serial bit entering at bit 0 on SHL
//   SinMsb  in  serial bit entering at the MSB on SHR
//   Q_next  out value the register takes if this operation executes
// -----------------------------------------------------------------------------
module usr_shift_core
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] Din,
  input  mode_e            mode,
  input  logic             SinLsb,
  input  logic             SinMsb,
  output logic [WIDTH-1:0] Q_next
);

  // Operation decode
  always_comb begin
    Q_next = Q;
    case (mode)
      MODE_HOLD: Q_next = Q;
      MODE_LOAD: Q_next = Din;
      MODE_SHL:  Q_next = {Q[WIDTH-2:0], SinLsb};
      MODE_SHR:  Q_next = {SinMsb, Q[WIDTH-1:1]};
      MODE_ROL:  Q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
      MODE_ROR:  Q_next = {Q[0], Q[WIDTH-1:1]};
      MODE_ASR:  Q_next = {Q[WIDTH-1], Q[WIDTH-1:1]};
      MODE_CLR:  Q_next = {WIDTH{1'b0}};
      default:   Q_next = Q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// Universal shift register with single-cycle operations and counted bursts.
//   CLK             in  clock, rising edge
//   RST             in  synchronous active-low reset
//   Din[WIDTH]      in  parallel load data
//   Mode[3]         in  operation select (see univ_shift_pkg::mode_e)
//   En              in  execute Mode once (IDLE only)
//   Start           in  begin a burst of Count shifts (IDLE, shift modes only)
//   Count[CNTW]     in  burst length, sampled with Start
//   SinLsb/SinMsb   in  serial-in bits, sampled live every executing edge
//   Dout[WIDTH]     out register contents
//   Busy            out burst in progress
//   Done            out one-cycle pulse after a burst (or a zero-length one)
//   SoutLsb/SoutMsb out serial-out bits, Dout[0] and Dout[WIDTH-1]
// -----------------------------------------------------------------------------
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int CNTW  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       Mode,
  input  logic             En,
  input  logic             Start,
  input  logic [CNTW-1:0]  Count,
  input  logic             SinLsb,
  input  logic             SinMsb,
  output logic [WIDTH-1:0] Dout,
  output logic             Busy,
  output logic             Done,
  output logic             SoutLsb,
  output logic             SoutMsb
);

  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_nxt_s;
  mode_e            mode_r;
  mode_e            mode_nxt_s;
  mode_e            mode_in_s;
  mode_e            core_mode_s;
  logic [CNTW-1:0]  cnt_r;
  logic [CNTW-1:0]  cnt_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] core_q_s;
  logic             busy_r;
  logic             done_r;
  logic             done_nxt_s;
  logic             start_ok_s;
  logic             last_s;

  assign mode_in_s  = mode_e'(Mode);
  // Start only counts for shift-family modes; otherwise En decides.
  assign start_ok_s = Start & is_burst_mode(mode_in_s);
  // Remaining count of one (or less, defensively) means this edge is the last.
  assign last_s     = (cnt_r <= CNT_ONE);

  // Burst executes the latched mode; IDLE executes the live mode.
  assign core_mode_s = (state_r == ST_BUSY) ? mode_r : mode_in_s;

  usr_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .Q      (q_r),
    .Din    (Din),
    .mode   (core_mode_s),
    .SinLsb (SinLsb),
    .SinMsb (SinMsb),
    .Q_next (core_q_s)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; illegal encodings recover to IDLE
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s && (Count != CNT_ZERO)) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and status next values for the current state
  always_comb begin
    q_nxt_s    = q_r;
    cnt_nxt_s  = cnt_r;
    mode_nxt_s = mode_r;
    done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          // Accepting a burst leaves Q untouched on this edge.
          mode_nxt_s = mode_in_s;
          cnt_nxt_s  = Count;
          if (Count == CNT_ZERO) begin
            done_nxt_s = 1'b1;
          end else begin
            done_nxt_s = 1'b0;
          end
        end else if (En) begin
          q_nxt_s = core_q_s;
        end else begin
          q_nxt_s = q_r;
        end
      end
      ST_BUSY: begin
        q_nxt_s   = core_q_s;
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (last_s) begin
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      default: begin
        cnt_nxt_s  = CNT_ZERO;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath, counter and registered status flags
  always_ff @(posedge CLK) begin
    if (!RST) begin
      q_r    <= {WIDTH{1'b0}};
      cnt_r  <= CNT_ZERO;
      mode_r <= MODE_HOLD;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      cnt_r  <= cnt_nxt_s;
      mode_r <= mode_nxt_s;
      busy_r <= (state_nxt_s == ST_BUSY);
      done_r <= done_nxt_s;
    end
  end

  assign Dout    = q_r;
  assign Busy    = busy_r;
  assign Done    = done_r;
  assign SoutLsb = q_r[0];
  assign SoutMsb = q_r[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed scenarios followed by random stimulus, every cycle compared with a
// behavioural model that works on plain integers.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int W    = 5;
  localparam int CW   = 3;
  localparam int MASK = (1 << W) - 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [W-1:0]  Din;
  logic [2:0]    Mode;
  logic          En;
  logic          Start;
  logic [CW-1:0] Count;
  logic          SinLsb;
  logic          SinMsb;
  logic [W-1:0]  Dout;
  logic          Busy;
  logic          Done;
  logic          SoutLsb;
  logic          SoutMsb;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: register value, burst bookkeeping, done pulse
  int m_q    = 0;
  int m_left = 0;
  int m_mode = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  always #5 CLK = ~CLK;

  univ_shift_reg #(.WIDTH(W), .CNTW(CW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Din     (Din),
    .Mode    (Mode),
    .En      (En),
    .Start   (Start),
    .Count   (Count),
    .SinLsb  (SinLsb),
    .SinMsb  (SinMsb),
    .Dout    (Dout),
    .Busy    (Busy),
    .Done    (Done),
    .SoutLsb (SoutLsb),
    .SoutMsb (SoutMsb)
  );

  // One operation on an integer value, using the live serial/data inputs.
  function automatic int apply(input int mode, input int q);
    case (mode)
      0:       return q;
      1:       return int'(Din);
      2:       return ((q * 2) + int'(SinLsb)) & MASK;
      3:       return (q / 2) + (int'(SinMsb) * (1 << (W - 1)));
      4:       return ((q * 2) & MASK) + (q / (1 << (W - 1)));
      5:       return (q / 2) + ((q % 2) * (1 << (W - 1)));
      6:       return (q / 2) + (q & (1 << (W - 1)));
      default: return 0;
    endcase
  endfunction

  // Advance the model by one rising edge.
  function automatic void model_update();
    if (RST == 1'b0) begin
      m_q = 0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else if (m_busy) begin
      m_q    = apply(m_mode, m_q);
      m_left = m_left - 1;
      m_busy = (m_left != 0);
      m_done = !m_busy;
    end else begin
      m_done = 1'b0;
      if (Start && int'(Mode) >= 2 && int'(Mode) <= 6) begin
        if (Count == 0) begin
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_left = int'(Count);
          m_mode = int'(Mode);
        end
      end else if (En) begin
        m_q = apply(int'(Mode), m_q);
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One clock: update model on the edge, compare everything on the falling edge.
  task automatic step(input string tag);
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    check({tag, ".dout"}, 32'(Dout), 32'(m_q));
    check({tag, ".busy"}, 32'(Busy), 32'(m_busy));
    check({tag, ".done"}, 32'(Done), 32'(m_done));
    check({tag, ".slsb"}, 32'(SoutLsb), 32'(m_q % 2));
    check({tag, ".smsb"}, 32'(SoutMsb), 32'(m_q / (1 << (W - 1))));
  endtask

  initial begin
    RST = 1'b0; Din = '0; Mode = 3'd0; En = 1'b0; Start = 1'b0;
    Count = '0; SinLsb = 1'b0; SinMsb = 1'b0;

    // reset
    step("reset");
    check("reset_const", 32'(Dout), 32'd0);

    // load and single-cycle rotates / arithmetic shift
    RST = 1'b1; Mode = 3'b001; Din = 5'b10110; En = 1'b1;
    step("load");
    check("load_const", 32'(Dout), 32'(5'b10110));
    Mode = 3'b100; step("rol"); check("rol_const", 32'(Dout), 32'(5'b01101));
    Mode = 3'b101; step("ror"); check("ror_const", 32'(Dout), 32'(5'b10110));
    Mode = 3'b110; step("asr"); check("asr_const", 32'(Dout), 32'(5'b11011));

    // SHR burst of 3
    Mode = 3'b001; Din = 5'b10110; step("reload");
    En = 1'b0; Mode = 3'b011; Count = 3'd3; Start = 1'b1; SinMsb = 1'b0;
    step("shr_k");
    check("shr_k_const", 32'(Dout), 32'(5'b10110));
    check("shr_k_busy", 32'(Busy), 32'd1);
    Start = 1'b0; Mode = 3'b000;
    step("shr_1"); check("shr_1_const", 32'(Dout), 32'(5'b01011));
    step("shr_2"); check("shr_2_const", 32'(Dout), 32'(5'b00101));
    step("shr_3"); check("shr_3_const", 32'(Dout), 32'(5'b00010));
    check("shr_done", 32'(Done), 32'd1);
    step("shr_after"); check("shr_done_drop", 32'(Done), 32'd0);

    // zero-length burst, then Start with a non-shift mode
    Start = 1'b1; Mode = 3'b010; Count = 3'd0;
    step("cnt0"); check("cnt0_done", 32'(Done), 32'd1);
    check("cnt0_busy", 32'(Busy), 32'd0);
    Mode = 3'b001; Din = 5'b11111; En = 1'b0;
    step("start_load"); check("start_load_const", 32'(Dout), 32'(5'b00010));
    check("start_load_done", 32'(Done), 32'd0);

    // reset in the second BUSY cycle of an SHL x5 burst
    Mode = 3'b010; Count = 3'd5; SinLsb = 1'b1;
    step("shl_k");
    Start = 1'b0;
    step("shl_1");
    RST = 1'b0;
    step("shl_rst");
    check("abort_const", 32'(Dout), 32'd0);
    RST = 1'b1;
    step("shl_after"); check("abort_no_done", 32'(Done), 32'd0);

    // back-to-back bursts, second Start issued in the Done cycle
    Mode = 3'b001; Din = 5'b10110; En = 1'b1;
    step("b2b_load");
    En = 1'b0; Mode = 3'b010; Count = 3'd2; Start = 1'b1;
    step("b2b_k");
    Start = 1'b0;
    step("b2b_1");
    step("b2b_2"); check("b2b_2_const", 32'(Dout), 32'(5'b11011));
    Start = 1'b1; Mode = 3'b101; Count = 3'd1;
    step("b2b_k2"); check("b2b_k2_busy", 32'(Busy), 32'd1);
    Start = 1'b0;
    step("b2b_end"); check("b2b_end_const", 32'(Dout), 32'(5'b11101));
    check("b2b_end_done", 32'(Done), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      RST    = ($urandom_range(0, 40) != 0);
      Din    = W'($urandom);
      Mode   = 3'($urandom);
      En     = 1'($urandom);
      Start  = ($urandom_range(0, 3) == 0);
      Count  = CW'($urandom);
      SinLsb = 1'($urandom);
      SinMsb = 1'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
